product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Downstream consumer of the unsigned multiplier's registered 2*WIDTH-bit product.
- Sums a programmable-length frame of products into one wide result (dot-product / MAC back end).
- Upstream handshake is valid/ready; downstream handshake is valid/ready.
- Flags accumulator wrap-around with a per-frame sticky overflow bit.

Parameters:
- WIDTH, 8: multiplier operand width; product input is 2*WIDTH bits.
- ACC_WIDTH, 2*WIDTH+8: accumulator/result width; must be >= 2*WIDTH.
- COUNT_WIDTH, 8: width of the frame-length input and the internal product counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort of the current frame
- len  in  COUNT_WIDTH  products per frame; sampled on the first accepted product of a frame
- prod_in  in  2*WIDTH  product from multiplier
- prod_valid  in  1  prod_in valid
- prod_ready  out  1  block accepts prod_in this cycle
- acc_out  out  ACC_WIDTH  frame sum
- acc_valid  out  1  acc_out/overflow valid
- acc_ready  in  1  consumer takes acc_out
- overflow  out  1  carry out of ACC_WIDTH occurred during frame
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc=0; count=0; acc_out=0; acc_valid=0; overflow=0; busy=0. prod_ready is 0 while rst_n=0, and 1 in IDLE afterwards.
- Accept: a product is accepted when prod_valid && prod_ready at the rising edge.
- States:
  - IDLE: prod_ready=1, acc_valid=0. On accept: latch len (len==0 treated as 1); load acc = zero-extended prod_in; count=1; overflow cleared. Go to ACCUM, or to HOLD if the effective len==1.
  - ACCUM: prod_ready=1. On accept: acc = acc + zero-extended prod_in, modulo 2^ACC_WIDTH; overflow |= carry out; count++. When count reaches len, go to HOLD. A cycle without prod_valid holds all state; no timeout.
  - HOLD: prod_ready=0; acc_valid=1; acc_out and overflow hold the final frame values and stay stable until acc_ready=1. On acc_valid && acc_ready, go to IDLE.
- Timing:
  - acc_valid rises the cycle after the last product is accepted (1-cycle latency).
  - Exactly one bubble cycle follows the handoff: the next frame's first product can be accepted in the cycle after the handoff, in IDLE.
  - acc_out is registered and keeps its last value after the handoff.
- Width rules:
  - count is compared against the latched len.
  - Max frame length is 2^COUNT_WIDTH - 1.
  - Only the output port overflow is sticky; acc wraps modulo 2^ACC_WIDTH.
- clear:
  - Highest priority after reset; acts in any state.
  - Next state is IDLE; acc=0, count=0, acc_valid=0, overflow=0.
  - A product presented in the same cycle as clear is dropped, even though prod_ready may read 1.
  - A result pending in HOLD is discarded.
- len changes mid-frame are ignored.
- acc_ready outside HOLD is ignored.
- Reset asserted mid-frame: all outputs go to reset values immediately, with no clock edge required.

Decomposition:
- Shared package: state enum {IDLE, ACCUM, HOLD} (2-bit encoding) and a function computing the ACC_WIDTH zero-extension of a product.
- Also in the package: a parameter check constant asserting ACC_WIDTH >= 2*WIDTH.
- No sub-module: counter, adder and FSM sit in one module of roughly 150 lines.

Test Plan:
- Basic frame. WIDTH=8, ACC_WIDTH=24, len=4; products 10, 20, 30, 40 on consecutive cycles -> acc_valid=1 one cycle after the 4th accept; acc_out=100; overflow=0; busy=1 throughout.
- Single product. len=1 and len=0, product 0xFE01 -> each frame goes directly to HOLD; acc_out=0x00FE01 on the next cycle.
- Overflow. ACC_WIDTH=16, len=2, products 0xFE01 and 0xFE01 -> acc_out=0xFC02, overflow=1; the next frame (len=1, product 5) gives acc_out=5, overflow=0.
- Backpressure. Complete a len=2 frame (7, 8), hold acc_ready=0 for 5 cycles while prod_valid=1 -> acc_out stays 15, prod_ready=0, no product consumed. Then raise acc_ready=1 -> handoff, one bubble, then the next product is accepted.
- Clear mid-frame. len=4, accept 3 and 4, pulse clear together with product 99 -> IDLE with 99 dropped. A new frame len=2 with 3, 4 then gives acc_out=7.
- Async reset mid-frame. Drop rst_n between clock edges during ACCUM -> acc_valid, acc_out, overflow and busy read 0 before the next edge; prod_ready=0 while rst_n=0, then 1 after release.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding,
// product zero-extension and the parameter sanity check.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_COUNT_WIDTH = 8;
  // Widest accumulator the zero-extension helper can produce.
  localparam int EXT_MAX_W       = 128;

  function automatic bit acc_width_ok(input int width, input int acc_width);
    return (acc_width >= 2 * width) && (acc_width <= EXT_MAX_W);
  endfunction

  function automatic logic [EXT_MAX_W-1:0] zext_prod(
    input logic [EXT_MAX_W-1:0] prod,
    input int                   prod_w
  );
    logic [EXT_MAX_W-1:0] mask;
    if (prod_w >= EXT_MAX_W) mask = '1;
    else                     mask = (EXT_MAX_W'(1) << prod_w) - EXT_MAX_W'(1);
    return prod & mask;
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a programmable-length frame of multiplier products into one wide
// result; valid/ready on both sides and a per-frame sticky overflow flag.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACC_WIDTH   = 2 * WIDTH + 8,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic [2*WIDTH-1:0]     prod_in,
  input  logic                   prod_valid,
  output logic                   prod_ready,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  input  logic                   acc_ready,
  output logic                   overflow,
  output logic                   busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid must not depend on ready, and the producer holds data
  // stable while valid is high and ready is low.

  localparam bit PARAMS_OK = acc_width_ok(WIDTH, ACC_WIDTH);

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("product_accumulator: ACC_WIDTH must be >= 2*WIDTH and <= EXT_MAX_W");
    end
  endgenerate

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_len;
  logic [ACC_WIDTH-1:0]   r_acc_out;
  logic                   r_acc_valid;
  logic                   r_overflow;

  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_ovf_next;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic [COUNT_WIDTH-1:0] w_len_eff;

  assign w_prod_ext   = ACC_WIDTH'(zext_prod(EXT_MAX_W'(prod_in), 2 * WIDTH));
  assign w_sum        = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_ovf_next   = r_overflow | w_sum[ACC_WIDTH];
  assign w_count_next = r_count + COUNT_WIDTH'(1);
  // A zero length would never terminate; it behaves as a one-product frame.
  assign w_len_eff    = (len == '0) ? COUNT_WIDTH'(1) : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_acc_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (prod_valid) begin
            r_acc      <= w_prod_ext;
            r_count    <= COUNT_WIDTH'(1);
            r_len      <= w_len_eff;
            r_overflow <= 1'b0;
            if (w_len_eff == COUNT_WIDTH'(1)) begin
              r_state     <= HOLD;
              r_acc_out   <= w_prod_ext;
              r_acc_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            r_acc      <= w_sum[ACC_WIDTH-1:0];
            r_overflow <= w_ovf_next;
            r_count    <= w_count_next;
            if (w_count_next == r_len) begin
              r_state     <= HOLD;
              r_acc_out   <= w_sum[ACC_WIDTH-1:0];
              r_acc_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            r_state     <= IDLE;
            r_acc_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc_valid <= 1'b0;
        end
      endcase
    end
  end

  // rst_n gates ready directly so nothing is accepted while reset is held.
  assign prod_ready = rst_n && (r_state != HOLD);
  assign acc_out    = r_acc_out;
  assign acc_valid  = r_acc_valid;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed stimulus for product_accumulator, checked by a
// scoreboard fed from an arithmetic frame-sum reference model.
module tb_product_accumulator;

  localparam int W  = 8;
  localparam int AW = 16;
  localparam int CW = 8;
  localparam int EW = AW + 1;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [CW-1:0] len;
  logic [2*W-1:0] prod_in;
  logic          prod_valid;
  logic          prod_ready;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          overflow;
  logic          busy;

  product_accumulator #(
    .WIDTH      (W),
    .ACC_WIDTH  (AW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .len       (len),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]  exp_q[$];
  logic [2*W-1:0] frame_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit ar_hold  = 1'b0;
  int gap_max  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random consumer backpressure unless a directed test owns acc_ready.
  always begin
    @(posedge clk);
    #1;
    if (!ar_hold) acc_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: every result handoff pops one expected {overflow, sum}.
  always @(negedge clk) begin
    if (rst_n && acc_valid && acc_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL result_unexpected: got acc=0x%0h ovf=%0b expected none", acc_out, overflow);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({overflow, acc_out} !== e) begin
          n_errors++;
          $display("FAIL result: got acc=0x%0h ovf=%0b expected acc=0x%0h ovf=%0b",
                   acc_out, overflow, e[AW-1:0], e[AW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2*W-1:0] p);
    bit ok;
    ok = 1'b0;
    prod_in    = p;
    prod_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = prod_ready;
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: product 0x%0h never accepted", p);
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends frame_q as one frame of length l and records the expected result.
  task automatic do_frame(input int l);
    longint tot;
    int     eff;
    eff = (l == 0) ? 1 : l;
    tot = 0;
    len = CW'(l);
    for (int k = 0; k < eff; k++) begin
      logic [2*W-1:0] p;
      p = frame_q.pop_front();
      tot += longint'(p);
      if (k > 0) idle_gap();
      send(p);
      if (k == 0) len = CW'($urandom);
      if (k < eff - 1) check("busy_in_frame", 32'(busy), 32'd1);
    end
    check("valid_latency", 32'(acc_valid), 32'd1);
    exp_q.push_back({(tot > 64'(16'hFFFF)) ? 1'b1 : 1'b0, tot[AW-1:0]});
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; len = '0; prod_in = '0;
    prod_valid = 1'b0; acc_ready = 1'b0;
    #12;
    check("rst_acc_valid", 32'(acc_valid), 32'd0);
    check("rst_acc_out", 32'(acc_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prod_ready", 32'(prod_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(prod_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic frame of four back-to-back products.
    frame_q = '{16'd10, 16'd20, 16'd30, 16'd40};
    do_frame(4);

    // Single-product frames, explicit and zero length.
    frame_q = '{16'hFE01};
    do_frame(1);
    frame_q = '{16'hFE01};
    do_frame(0);

    // Wrap-around then a clean frame that must clear the sticky flag.
    frame_q = '{16'hFE01, 16'hFE01};
    do_frame(2);
    frame_q = '{16'd5};
    do_frame(1);
    drain();

    // Backpressure: result held, nothing consumed, one bubble after handoff.
    ar_hold = 1'b1;
    acc_ready = 1'b0;
    frame_q = '{16'd7, 16'd8};
    do_frame(2);
    len = CW'(1);
    prod_in = 16'd55;
    prod_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_acc_out", 32'(acc_out), 32'd15);
      check("bp_prod_ready", 32'(prod_ready), 32'd0);
      check("bp_acc_valid", 32'(acc_valid), 32'd1);
    end
    acc_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bubble_valid", 32'(acc_valid), 32'd0);
    check("bubble_busy", 32'(busy), 32'd0);
    check("bubble_ready", 32'(prod_ready), 32'd1);
    exp_q.push_back({1'b0, 16'd55});
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    check("after_bubble_accept", 32'(acc_valid), 32'd1);
    drain();
    ar_hold = 1'b0;

    // Clear mid-frame drops the colliding product.
    frame_q = '{16'd3, 16'd4};
    len = CW'(4);
    send(frame_q.pop_front());
    send(frame_q.pop_front());
    clear = 1'b1;
    prod_in = 16'd99;
    prod_valid = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    prod_valid = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_acc_valid", 32'(acc_valid), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    frame_q = '{16'd3, 16'd4};
    do_frame(2);

    // Randomized frames with gaps, large products and one long frame.
    gap_max = 2;
    for (int f = 0; f < 24; f++) begin
      int l;
      int eff;
      l = (f == 7) ? 255 : $urandom_range(0, 6);
      eff = (l == 0) ? 1 : l;
      for (int k = 0; k < eff; k++) begin
        if ($urandom_range(0, 1) == 1) frame_q.push_back(16'($urandom_range(16'hC000, 16'hFFFF)));
        else                           frame_q.push_back(16'($urandom));
      end
      do_frame(l);
    end
    gap_max = 0;
    drain();

    // Asynchronous reset in ACCUM with overflow already set.
    frame_q = '{16'hFE01, 16'hFE01};
    len = CW'(4);
    send(frame_q.pop_front());
    send(frame_q.pop_front());
    check("pre_arst_overflow", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_acc_valid", 32'(acc_valid), 32'd0);
    check("arst_acc_out", 32'(acc_out), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_prod_ready", 32'(prod_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", 32'(prod_ready), 32'd1);
    @(posedge clk);
    #1;
    frame_q = '{16'd1, 16'd2};
    do_frame(2);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
